conv1x1_weight_loader: RTL and testbench

- Sequencer that streams 1x1-convolution coefficients from a valid/ready weight source into the residual block's conv1x1 coefficient-write port.
- The port signals are conv1x1_h_write[1:0], conv1x1_h_index_in, conv1x1_h_index_out and conv1x1_h_value.
- It walks every (out, in) coefficient index for the residual path and/or the skip path, then signals completion.
- It sits between the host/DMA weight stream and one residual block instance.

---
 rtl/conv1x1_weight_loader_if.sv | 33 +++
 rtl/conv1x1_weight_loader.sv | 127 ++++++++++++
 tb/tb_conv1x1_weight_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1x1_weight_loader_if.sv
// Weight-stream input and conv1x1 coefficient-write port bundled for the loader.
// The loader owns the master side; the weight source / residual block side uses slave.
interface conv1x1_weight_loader_if #(
    parameter int unsigned DATA_W = 16
);
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;
    logic [1:0]        conv1x1_h_write;
    logic [15:0]       conv1x1_h_index_in;
    logic [15:0]       conv1x1_h_index_out;
    logic [DATA_W-1:0] conv1x1_h_value;

    modport master (
        input  w_valid,
        input  w_data,
        output w_ready,
        output conv1x1_h_write,
        output conv1x1_h_index_in,
        output conv1x1_h_index_out,
        output conv1x1_h_value
    );

    modport slave (
        output w_valid,
        output w_data,
        input  w_ready,
        input  conv1x1_h_write,
        input  conv1x1_h_index_in,
        input  conv1x1_h_index_out,
        input  conv1x1_h_value
    );
endinterface

// File: rtl/conv1x1_weight_loader.sv
// Streams conv1x1 coefficients from a valid/ready source into a residual block's
// coefficient-write port, walking (out, in) out-major for the residual and/or skip path.
module conv1x1_weight_loader #(
    parameter int unsigned IN_CHANNELS  = 512,
    parameter int unsigned OUT_CHANNELS = 512,
    parameter int unsigned DATA_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    path_mask,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    conv1x1_weight_loader_if.master       bus
);

    localparam int unsigned IN_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int unsigned OUT_W = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_CHANNELS - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_RES,
        LOAD_SKIP,
        DONE
    } state_t;

    state_t           state;
    logic [IN_W-1:0]  idx_in;
    logic [OUT_W-1:0] idx_out;
    // Only the skip bit matters after start: it decides whether LOAD_RES chains into LOAD_SKIP.
    logic             skip_latched;
    logic             accept;
    logic             last_beat;

    // Source may only hand over a beat while a path is loading and no abort is pending.
    always_comb begin
        bus.w_ready = 1'b0;
        if ((state == LOAD_RES || state == LOAD_SKIP) && !abort) begin
            bus.w_ready = 1'b1;
        end
    end

    assign accept    = bus.w_valid && bus.w_ready;
    assign last_beat = (idx_in == IN_LAST) && (idx_out == OUT_LAST);

    // Sequencer, index counters and registered write-port / status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            idx_in                  <= '0;
            idx_out                 <= '0;
            skip_latched            <= 1'b0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            aborted                 <= 1'b0;
            bus.conv1x1_h_write     <= 2'b00;
            bus.conv1x1_h_index_in  <= '0;
            bus.conv1x1_h_index_out <= '0;
            bus.conv1x1_h_value     <= '0;
        end else begin
            // Strobes and pulses default low; indices and value hold.
            bus.conv1x1_h_write <= 2'b00;
            done                <= 1'b0;
            aborted             <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        skip_latched <= path_mask[0];
                        idx_in       <= '0;
                        idx_out      <= '0;
                        if (path_mask[1]) begin
                            state <= LOAD_RES;
                            busy  <= 1'b1;
                        end else if (path_mask[0]) begin
                            state <= LOAD_SKIP;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD_RES, LOAD_SKIP: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        idx_in  <= '0;
                        idx_out <= '0;
                    end else if (accept) begin
                        bus.conv1x1_h_write     <= (state == LOAD_RES) ? 2'b10 : 2'b01;
                        bus.conv1x1_h_index_in  <= 16'(idx_in);
                        bus.conv1x1_h_index_out <= 16'(idx_out);
                        bus.conv1x1_h_value     <= bus.w_data;
                        if (last_beat) begin
                            idx_in  <= '0;
                            idx_out <= '0;
                            if (state == LOAD_RES && skip_latched) begin
                                state <= LOAD_SKIP;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (idx_in == IN_LAST) begin
                            idx_in  <= '0;
                            idx_out <= idx_out + OUT_W'(1);
                        end else begin
                            idx_in <= idx_in + IN_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv1x1_weight_loader.sv
// Self-checking bench for conv1x1_weight_loader: table-driven loads, an async-reset
// sequence and randomized loads, all checked cycle by cycle against a beat-count model.
module tb_conv1x1_weight_loader;

    localparam int IN_CH    = 3;
    localparam int OUT_CH   = 2;
    localparam int DW       = 16;
    localparam int PER_PATH = IN_CH * OUT_CH;
    localparam int BUDGET   = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] path_mask = 2'b00;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       aborted;

    conv1x1_weight_loader_if #(.DATA_W(DW)) bus_if ();

    conv1x1_weight_loader #(
        .IN_CHANNELS (IN_CH),
        .OUT_CHANNELS(OUT_CH),
        .DATA_W      (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .path_mask(path_mask),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 loading, 2 done; beats counted across both paths.
    int          m_ph;
    int          m_beats;
    int          m_total;
    logic [1:0]  m_mask;
    logic [1:0]  e_write;
    logic [15:0] e_in;
    logic [15:0] e_out;
    logic [DW-1:0] e_val;
    logic        e_busy;
    logic        e_done;
    logic        e_aborted;
    logic [DW-1:0] val_ctr;

    int n_tests;
    int n_fail;
    int obs_writes;
    int obs_busy;
    int obs_done;
    int obs_aborted;

    typedef struct {
        logic [1:0] mask;
        int         vmode;      // 0 valid held, 1 toggling 1,0,1,0, 2 random
        int         abort_at;   // offered-beat index carrying abort, -1 none
        bit         restart;    // pulse start while busy
        int         exp_writes;
        int         exp_busy;
        int         exp_done;
        int         exp_aborted;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph      = 0;
        m_beats   = 0;
        m_total   = 0;
        m_mask    = 2'b00;
        e_write   = 2'b00;
        e_in      = '0;
        e_out     = '0;
        e_val     = '0;
        e_busy    = 1'b0;
        e_done    = 1'b0;
        e_aborted = 1'b0;
    endtask

    task automatic model_edge(input logic acc);
        int k;
        e_write   = 2'b00;
        e_done    = 1'b0;
        e_aborted = 1'b0;
        case (m_ph)
            0: begin
                if (start) begin
                    m_mask  = path_mask;
                    m_beats = 0;
                    m_total = (int'(path_mask[1]) + int'(path_mask[0])) * PER_PATH;
                    if (m_total == 0) begin
                        m_ph   = 2;
                        e_done = 1'b1;
                    end else begin
                        m_ph   = 1;
                        e_busy = 1'b1;
                    end
                end
            end
            1: begin
                if (abort) begin
                    m_ph      = 0;
                    e_busy    = 1'b0;
                    e_aborted = 1'b1;
                end else if (acc) begin
                    k       = m_beats % PER_PATH;
                    e_write = (m_beats < PER_PATH && m_mask[1]) ? 2'b10 : 2'b01;
                    e_out   = 16'(k / IN_CH);
                    e_in    = 16'(k % IN_CH);
                    e_val   = bus_if.w_data;
                    m_beats++;
                    val_ctr++;
                    if (m_beats == m_total) begin
                        m_ph   = 2;
                        e_busy = 1'b0;
                        e_done = 1'b1;
                    end
                end
            end
            default: m_ph = 0;
        endcase
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".h_write"}, 32'(bus_if.conv1x1_h_write), 32'd0);
        chk({tag, ".index_in"}, 32'(bus_if.conv1x1_h_index_in), 32'd0);
        chk({tag, ".index_out"}, 32'(bus_if.conv1x1_h_index_out), 32'd0);
        chk({tag, ".value"}, 32'(bus_if.conv1x1_h_value), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".aborted"}, 32'(aborted), 32'd0);
        chk({tag, ".w_ready"}, 32'(bus_if.w_ready), 32'd0);
    endtask

    // One clock: entered at a falling edge with inputs already driven.
    task automatic step();
        logic exp_ready;
        logic acc;
        #1;
        exp_ready = (m_ph == 1) && !abort;
        chk("w_ready", 32'(bus_if.w_ready), 32'(exp_ready));
        if (busy) obs_busy++;
        acc = exp_ready && bus_if.w_valid;
        @(posedge clk);
        #1;
        model_edge(acc);
        chk("h_write", 32'(bus_if.conv1x1_h_write), 32'(e_write));
        chk("index_in", 32'(bus_if.conv1x1_h_index_in), 32'(e_in));
        chk("index_out", 32'(bus_if.conv1x1_h_index_out), 32'(e_out));
        chk("value", 32'(bus_if.conv1x1_h_value), 32'(e_val));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("aborted", 32'(aborted), 32'(e_aborted));
        if (bus_if.conv1x1_h_write != 2'b00) obs_writes++;
        if (done) obs_done++;
        if (aborted) obs_aborted++;
        @(negedge clk);
    endtask

    task automatic run_load(input vec_t v, input string tag);
        int   offered;
        int   cyc;
        logic vld;
        obs_writes  = 0;
        obs_busy    = 0;
        obs_done    = 0;
        obs_aborted = 0;
        val_ctr     = 1;
        start          = 1'b1;
        path_mask      = v.mask;
        abort          = 1'b0;
        bus_if.w_valid = 1'b0;
        bus_if.w_data  = '0;
        step();
        start   = 1'b0;
        offered = 0;
        cyc     = 0;
        while (m_ph != 0 && cyc < BUDGET) begin
            if (v.vmode == 0) vld = 1'b1;
            else if (v.vmode == 1) vld = (cyc % 2 == 0);
            else vld = 1'($urandom_range(0, 1));
            bus_if.w_valid = vld;
            bus_if.w_data  = (v.vmode == 2) ? DW'($urandom) : val_ctr;
            abort     = (v.abort_at >= 0) && vld && (m_ph == 1) && (offered == v.abort_at);
            start     = v.restart && (cyc == 2);
            path_mask = 2'($urandom_range(0, 3));
            if (vld && m_ph == 1) offered++;
            step();
            cyc++;
        end
        abort          = 1'b0;
        start          = 1'b0;
        bus_if.w_valid = 1'b0;
        chk({tag, ".finished"}, 32'(cyc < BUDGET), 32'd1);
        if (v.exp_writes >= 0) begin
            chk({tag, ".writes"}, 32'(obs_writes), 32'(v.exp_writes));
            chk({tag, ".busy_cycles"}, 32'(obs_busy), 32'(v.exp_busy));
            chk({tag, ".done_pulses"}, 32'(obs_done), 32'(v.exp_done));
            chk({tag, ".aborted_pulses"}, 32'(obs_aborted), 32'(v.exp_aborted));
        end
    endtask

    initial begin
        vec_t rv;
        n_tests = 0;
        n_fail  = 0;
        val_ctr = 1;
        model_reset();
        bus_if.w_valid = 1'b0;
        bus_if.w_data  = '0;

        vecs[0] = '{2'b10, 0, -1, 1'b0, 6, 6, 1, 0};
        vecs[1] = '{2'b11, 0, -1, 1'b0, 12, 12, 1, 0};
        vecs[2] = '{2'b01, 1, -1, 1'b0, 6, 11, 1, 0};
        vecs[3] = '{2'b00, 0, -1, 1'b0, 0, 0, 1, 0};
        vecs[4] = '{2'b11, 0, 3, 1'b0, 3, 4, 0, 1};
        vecs[5] = '{2'b10, 0, -1, 1'b1, 6, 6, 1, 0};

        @(negedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset partway through a skip-path load.
        val_ctr        = 1;
        start          = 1'b1;
        path_mask      = 2'b01;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.w_valid = 1'b1;
            bus_if.w_data  = val_ctr;
            step();
        end
        chk("pre_reset.index_in", 32'(bus_if.conv1x1_h_index_in), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        @(posedge clk);
        #1;
        chk("reset_hold.done", 32'(done), 32'd0);
        chk("reset_hold.aborted", 32'(aborted), 32'd0);
        model_reset();
        @(negedge clk);
        reset          = 1'b0;
        bus_if.w_valid = 1'b0;
        @(negedge clk);
        run_load(vecs[0], "after_reset");

        for (int i = 0; i < 8; i++) begin
            rv.mask        = 2'($urandom_range(0, 3));
            rv.vmode       = 2;
            rv.abort_at    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
            rv.restart     = 1'($urandom_range(0, 1));
            rv.exp_writes  = -1;
            rv.exp_busy    = -1;
            rv.exp_done    = -1;
            rv.exp_aborted = -1;
            run_load(rv, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
